// File: rtl/button_debouncer_bank_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_bank_pkg
//
// Shared constants for the button/switch debouncer bank.
//   CYCLES_250MS  : 250 ms of stability at a 100 MHz cclk (default debounce time)
//   CYCLES_10MS   : 10 ms at 100 MHz, a shorter setting for well-behaved switches
//   rep_state_e   : per-channel auto-repeat state (IDLE, or HELD split into
//                   DELAY and PERIOD phases)
// -----------------------------------------------------------------------------
package button_debouncer_bank_pkg;

   localparam int unsigned CYCLES_250MS = 25_000_000;
   localparam int unsigned CYCLES_10MS  = 1_000_000;

   localparam int unsigned REP_STATE_W  = 2;

   typedef enum logic [REP_STATE_W-1:0] {
      REP_IDLE   = 2'd0,   // debounced level is 0
      REP_DELAY  = 2'd1,   // held, waiting for the first repeat tick
      REP_PERIOD = 2'd2    // held, ticking every REPEAT_PERIOD cycles
   } rep_state_e;

endpackage

// File: rtl/button_debouncer_bank_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//
// One input of the debouncer bank: two-flop synchroniser, stability counter,
// registered rise/fall pulses and an optional auto-repeat state machine.
//
// Parameters:
//   CYCLES        consecutive differing samples needed to accept a new level
//   COUNTER_WIDTH width of the stability counter (holds CYCLES-1)
//   RESET_VALUE   reset level of the synchroniser flops and debounced
//   REPEAT_ENA    1 enables the auto-repeat press strobe
//   REPEAT_DELAY  cycles from rise to the first repeat tick
//   REPEAT_PERIOD cycles between later repeat ticks
//   REPEAT_WIDTH  width of the repeat counter
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   bouncy     in   raw asynchronous input
//   debounced  out  clean registered level
//   rise       out  one-cycle pulse in the first cycle debounced reads 1
//   fall       out  one-cycle pulse in the first cycle debounced reads 0
//   press      out  rise, or a repeat tick while held
//   rep_state  out  current repeat state (debug visibility)
//
// Handshake: none. Every output is a registered level or a single-cycle
// strobe, valid every cycle, with no valid/ready qualification.
// -----------------------------------------------------------------------------
module debounce_channel
   import button_debouncer_bank_pkg::*;
#(
   parameter int unsigned CYCLES        = CYCLES_250MS,
   parameter int unsigned COUNTER_WIDTH = 32,
   parameter logic        RESET_VALUE   = 1'b0,
   parameter logic        REPEAT_ENA    = 1'b0,
   parameter int unsigned REPEAT_DELAY  = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = 10_000_000,
   parameter int unsigned REPEAT_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   bouncy,
   output logic                   debounced,
   output logic                   rise,
   output logic                   fall,
   output logic                   press,
   output logic [REP_STATE_W-1:0] rep_state
);

   localparam logic [COUNTER_WIDTH-1:0] CNT_LAST    = COUNTER_WIDTH'(CYCLES - 1);
   localparam logic [REPEAT_WIDTH-1:0]  DELAY_LAST  = REPEAT_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [REPEAT_WIDTH-1:0]  PERIOD_LAST = REPEAT_WIDTH'(REPEAT_PERIOD - 1);

   // synchroniser
   logic s1_q;
   logic s2_q;

   // stability counter and registered outputs
   logic [COUNTER_WIDTH-1:0] cnt_q;
   logic [COUNTER_WIDTH-1:0] cnt_d;
   logic                     deb_q;
   logic                     deb_d;
   logic                     rise_q;
   logic                     rise_d;
   logic                     fall_q;
   logic                     fall_d;
   logic                     press_q;
   logic                     press_d;
   logic                     toggle;

   // auto-repeat
   rep_state_e               rep_q;
   rep_state_e               rep_d;
   logic [REPEAT_WIDTH-1:0]  rcnt_q;
   logic [REPEAT_WIDTH-1:0]  rcnt_d;
   logic                     tick_d;

   // --------------------------------------------------------------------------
   // Stability counter. The counter runs only while the synchronised input
   // disagrees with the accepted level; any agreeing sample restarts it, so
   // only CYCLES consecutive disagreeing samples flip the output.
   // --------------------------------------------------------------------------
   always_comb begin
      toggle = 1'b0;
      cnt_d  = '0;
      if (s2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            toggle = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      deb_d  = deb_q ^ toggle;
      // Pulses are computed from the same toggle so they register on the
      // same edge as the new level.
      rise_d = toggle & ~deb_q;
      fall_d = toggle &  deb_q;
   end

   // --------------------------------------------------------------------------
   // Repeat FSM. rcnt_q counts edges since the last rise or tick; a tick
   // fires on the edge where it reaches the phase length minus one.
   // A fall always wins over a tick in the same cycle.
   // --------------------------------------------------------------------------
   always_comb begin
      rep_d  = rep_q;
      rcnt_d = rcnt_q;
      tick_d = 1'b0;
      case (rep_q)
         REP_IDLE: begin
            if (REPEAT_ENA && rise_d) begin
               rep_d  = REP_DELAY;
               rcnt_d = '0;
            end
         end
         REP_DELAY: begin
            if (fall_d) begin
               rep_d  = REP_IDLE;
               rcnt_d = '0;
            end else if (rcnt_q == DELAY_LAST) begin
               tick_d = 1'b1;
               rep_d  = REP_PERIOD;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         REP_PERIOD: begin
            if (fall_d) begin
               rep_d  = REP_IDLE;
               rcnt_d = '0;
            end else if (rcnt_q == PERIOD_LAST) begin
               tick_d = 1'b1;
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         default: begin
            rep_d  = REP_IDLE;
            rcnt_d = '0;
         end
      endcase
      press_d = rise_d | tick_d;
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= RESET_VALUE;
         s2_q    <= RESET_VALUE;
         deb_q   <= RESET_VALUE;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         press_q <= 1'b0;
         rep_q   <= REP_IDLE;
         rcnt_q  <= '0;
      end else begin
         s1_q    <= bouncy;
         s2_q    <= s1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         press_q <= press_d;
         rep_q   <= rep_d;
         rcnt_q  <= rcnt_d;
      end
   end

   assign debounced = deb_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign press     = press_q;
   assign rep_state = rep_q;

endmodule

// File: rtl/button_debouncer_bank.sv
// -----------------------------------------------------------------------------
// button_debouncer_bank
//
// CHANNELS independent debouncers for board buttons and switches in the cclk
// domain. Each channel yields a clean level, rise/fall pulses and a press
// strobe that auto-repeats while held on channels selected by REPEAT_MASK.
//
// Parameters:
//   CHANNELS       number of inputs
//   CYCLES         stable cycles required to accept a new level (>= 2)
//   COUNTER_WIDTH  stability counter width (holds CYCLES-1)
//   RESET_VALUE    per-channel reset level
//   REPEAT_MASK    per-channel auto-repeat enable
//   REPEAT_DELAY   held cycles from rise to first repeat tick (>= 1)
//   REPEAT_PERIOD  cycles between subsequent repeat ticks (>= 1)
//   REPEAT_WIDTH   repeat counter width
//
// Ports:
//   clk            in   system clock (cclk)
//   rst            in   asynchronous active-high reset
//   bouncy         in   raw asynchronous inputs
//   debounced      out  clean registered levels
//   rise           out  one-cycle 0->1 pulses
//   fall           out  one-cycle 1->0 pulses
//   press          out  rise or auto-repeat tick strobes
//   rep_state_dbg  out  2 bits per channel: repeat state of channel g at
//                       [2g+1:2g]
//
// Handshake: none; all outputs are registered and valid every cycle.
// -----------------------------------------------------------------------------
module button_debouncer_bank
   import button_debouncer_bank_pkg::*;
#(
   parameter int unsigned         CHANNELS      = 5,
   parameter int unsigned         CYCLES        = CYCLES_250MS,
   parameter int unsigned         COUNTER_WIDTH = 32,
   parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{1'b0}},
   parameter logic [CHANNELS-1:0] REPEAT_MASK   = {CHANNELS{1'b0}},
   parameter int unsigned         REPEAT_DELAY  = 50_000_000,
   parameter int unsigned         REPEAT_PERIOD = 10_000_000,
   parameter int unsigned         REPEAT_WIDTH  = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [CHANNELS-1:0]               bouncy,
   output logic [CHANNELS-1:0]               debounced,
   output logic [CHANNELS-1:0]               rise,
   output logic [CHANNELS-1:0]               fall,
   output logic [CHANNELS-1:0]               press,
   output logic [REP_STATE_W*CHANNELS-1:0]   rep_state_dbg
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      debounce_channel #(
         .CYCLES        (CYCLES),
         .COUNTER_WIDTH (COUNTER_WIDTH),
         .RESET_VALUE   (RESET_VALUE[g]),
         .REPEAT_ENA    (REPEAT_MASK[g]),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .REPEAT_WIDTH  (REPEAT_WIDTH)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .bouncy    (bouncy[g]),
         .debounced (debounced[g]),
         .rise      (rise[g]),
         .fall      (fall[g]),
         .press     (press[g]),
         .rep_state (rep_state_dbg[REP_STATE_W*g +: REP_STATE_W])
      );
   end

endmodule

// File: tb/tb_button_debouncer_bank.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer_bank
//
// Bench for button_debouncer_bank with CHANNELS=3, CYCLES=4, REPEAT_MASK=001,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. A reference model samples the inputs at
// every clock edge and pushes the expected {press, fall, rise, debounced}
// word into exp_q; a monitor pops and compares on the falling edge. A level
// is accepted when the last CYCLES synchronised samples all disagree with it;
// repeat ticks are placed arithmetically from the rise edge.
// -----------------------------------------------------------------------------
module tb_button_debouncer_bank;
   localparam int CH  = 3;
   localparam int CYC = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;
   localparam logic [CH-1:0] RV = 3'b000;
   localparam logic [CH-1:0] RM = 3'b001;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [CH-1:0]   bouncy = RV;
   logic [CH-1:0]   debounced;
   logic [CH-1:0]   rise;
   logic [CH-1:0]   fall;
   logic [CH-1:0]   press;
   logic [2*CH-1:0] rep_dbg;

   button_debouncer_bank #(
      .CHANNELS      (CH),
      .CYCLES        (CYC),
      .COUNTER_WIDTH (8),
      .RESET_VALUE   (RV),
      .REPEAT_MASK   (RM),
      .REPEAT_DELAY  (RD),
      .REPEAT_PERIOD (RP),
      .REPEAT_WIDTH  (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bouncy        (bouncy),
      .debounced     (debounced),
      .rise          (rise),
      .fall          (fall),
      .press         (press),
      .rep_state_dbg (rep_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [CH-1:0]   samp_q[$];
   logic [CH-1:0]   m_deb;
   int              rise_at[CH];
   int              edge_n = 0;
   logic [4*CH-1:0] exp_q[$];
   int              checks = 0;
   int              failures = 0;

   // directed latency watches: stimulus bumps watch_id, monitor retires
   int watch_edge[CH];
   int watch_id[CH];
   int seen_id[CH];

   task automatic model_reset();
      samp_q.delete();
      for (int i = 0; i < CYC + 2; i++) samp_q.push_back(RV);
      m_deb = RV;
      for (int c = 0; c < CH; c++) rise_at[c] = -1;
   endtask

   initial begin
      logic [CH-1:0] r, f, p;
      logic          all_diff, tk;
      int            el;
      model_reset();
      forever begin
         @(posedge clk);
         edge_n++;
         if (rst) begin
            model_reset();
            exp_q.push_back('0);
         end else begin
            samp_q.push_back(bouncy);
            void'(samp_q.pop_front());
            for (int c = 0; c < CH; c++) begin
               // samp_q[CYC+1] was sampled at this edge; the synchroniser
               // output compared now is two samples older.
               all_diff = 1'b1;
               for (int i = 0; i < CYC; i++)
                  if (samp_q[CYC-1-i][c] == m_deb[c]) all_diff = 1'b0;
               r[c] = all_diff & ~m_deb[c];
               f[c] = all_diff &  m_deb[c];
               tk = 1'b0;
               if (RM[c] && m_deb[c] && !f[c] && rise_at[c] >= 0) begin
                  el = edge_n - rise_at[c];
                  if (el >= RD && ((el - RD) % RP) == 0) tk = 1'b1;
               end
               if (r[c]) rise_at[c] = edge_n;
               if (f[c]) rise_at[c] = -1;
               m_deb[c] = m_deb[c] ^ all_diff;
               p[c] = r[c] | tk;
            end
            exp_q.push_back({p, f, r, m_deb});
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [4*CH-1:0] exp_w, act_w;
      for (int c = 0; c < CH; c++) seen_id[c] = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            act_w = {press, fall, rise, debounced};
            checks++;
            if (act_w !== exp_w) begin
               failures++;
               if (failures <= 40)
                  $display("FAIL scoreboard edge=%0d got=%b want=%b (press,fall,rise,deb)",
                           edge_n, act_w, exp_w);
            end
            checks++;
            if ((rise & fall) != '0) begin
               failures++;
               $display("FAIL rise_fall_exclusive edge=%0d rise=%b fall=%b", edge_n, rise, fall);
            end
            for (int c = 0; c < CH; c++) begin
               if (watch_id[c] != seen_id[c]) begin
                  if (rise[c]) begin
                     checks++;
                     if (edge_n != watch_edge[c]) begin
                        failures++;
                        $display("FAIL rise_latency ch%0d got_edge=%0d want_edge=%0d",
                                 c, edge_n, watch_edge[c]);
                     end
                     seen_id[c] = watch_id[c];
                  end else if (edge_n >= watch_edge[c] + 3) begin
                     checks++;
                     failures++;
                     $display("FAIL rise_timeout ch%0d got=none want_edge=%0d", c, watch_edge[c]);
                     seen_id[c] = watch_id[c];
                  end
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input int c, input logic v, output int k);
      @(posedge clk);
      #2;
      bouncy[c] = v;
      k = edge_n + 1;   // first edge that samples the new level
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic expect_rise(input int c, input int e);
      watch_edge[c] = e;
      watch_id[c]   = watch_id[c] + 1;
   endtask

   task automatic reset_pulse(input int hold, output int rel);
      @(posedge clk);
      #7;
      rst = 1'b1;
      repeat (hold) @(posedge clk);
      #7;
      rst = 1'b0;
      rel = edge_n;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int k, r0, rel;
      for (int c = 0; c < CH; c++) watch_id[c] = 0;
      idle(3);
      @(posedge clk);
      #7;
      rst = 1'b0;
      idle(10);

      // clean step on ch0, then hold for auto-repeat and release
      drive(0, 1'b1, k);
      expect_rise(0, k + CYC + 1);
      r0 = k + CYC + 1;
      while (edge_n < r0 + 23) @(posedge clk);
      drive(0, 1'b0, k);       // fall lands at r0+30, last tick at r0+28
      idle(12);

      // glitch on ch1: three sampled high cycles
      drive(1, 1'b1, k);
      idle(2);
      drive(1, 1'b0, k);
      idle(15);

      // chatter on ch1, then hold high (mask off: press only at rise)
      for (int i = 0; i < 10; i++) begin
         drive(1, ~bouncy[1], k);
         idle(1);
      end
      drive(1, 1'b1, k);
      expect_rise(1, k + CYC + 1);
      idle(35);
      drive(1, 1'b0, k);
      idle(10);

      // reset mid-repeat on ch0 and mid-count on ch2
      drive(0, 1'b1, k);
      idle(20);
      drive(2, 1'b1, k);
      idle(1);
      reset_pulse(3, rel);
      expect_rise(0, rel + 6);
      expect_rise(2, rel + 6);
      idle(30);
      drive(0, 1'b0, k);
      drive(2, 1'b0, k);
      idle(12);

      // random stimulus with occasional resets
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            reset_pulse($urandom_range(1, 3), rel);
         end else begin
            drive($urandom_range(0, CH - 1), 1'($urandom_range(0, 1)), k);
            idle($urandom_range(0, 12));
         end
      end
      bouncy = RV;
      idle(40);
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
